// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select add/sub unit: one SEG-bit segment resolves per clock,
// with the inter-segment carry registered and a global valid/ready stall.
module pipelined_carry_select_adder #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned BLK    = 4,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned NBLK = SEG / BLK;
    localparam int unsigned LAST = STAGES - 1;

    generate
        if ((WIDTH % (BLK * STAGES)) != 0) begin : g_bad_cfg
            $error("WIDTH must be a multiple of BLK*STAGES");
        end
    endgenerate

    // Carry-select segment: each block precomputes both carry-in cases, the
    // incoming carry then picks sum and carry-out block by block.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           cin);
        logic [SEG-1:0] s;
        logic           c;
        logic [BLK:0]   r0;
        logic [BLK:0]   r1;
        s = '0;
        c = cin;
        for (int unsigned i = 0; i < NBLK; i++) begin
            r0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]};
            r1 = {1'b0, a[i*BLK +: BLK]} + {1'b0, b[i*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
            s[i*BLK +: BLK] = c ? r1[BLK-1:0] : r0[BLK-1:0];
            c = c ? r1[BLK] : r0[BLK];
        end
        return {c, s};
    endfunction

    logic              advance;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    logic [STAGES-1:0] src_v;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [SEG:0]      seg_res;

    assign advance    = ~out_valid_o | out_ready_i;
    assign in_ready_o = advance;

    always_comb begin
        // Stage 0 is fed by the conditioned operands; stage k>0 by stage k-1.
        src_v[0]   = in_valid_i;
        src_c[0]   = cin_i ^ sub_i;
        src_a[0]   = a_i;
        src_b[0]   = sub_i ? ~b_i : b_i;
        src_sum[0] = '0;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_v[k]   = valid_q[k-1];
            src_c[k]   = carry_q[k-1];
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_sum[k] = sum_q[k-1];
        end

        seg_res = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg_res    = seg_add(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k]);
            valid_d[k] = src_v[k];
            carry_d[k] = seg_res[SEG];
            a_d[k]     = src_a[k];
            b_d[k]     = src_b[k];
            sum_d[k]   = src_sum[k];
            sum_d[k][k*SEG +: SEG] = seg_res[SEG-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign out_valid_o = valid_q[LAST];
    assign sum_o       = sum_q[LAST];
    assign cout_o      = carry_q[LAST];
    assign ovf_o       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &
                         (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule
